pll_lock_sequencer: RTL and testbench

//  Sequences the iCE40 PLL at power-up and on lock loss: pulses the PLL RESETB, waits for LOCK,

---
 rtl/pll_lock_sequencer.sv | 157 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-loss sequencer for the iCE40 PLL, clocked from the 12 MHz reference.
// Pulses RESETB, waits for a synchronised LOCK, qualifies it, then raises sys_ready.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 12000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_ATTEMPTS  = 7,
    parameter int CNT_W         = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked_async,
    input  logic       retry,
    output logic       pll_resetb,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [2:0] attempt_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       ATT_MAX  = 3'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             lk_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [2:0]       att_q, att_d;
    logic [7:0]       loss_q, loss_d;
    logic             resetb_q;
    logic             ready_q;
    logic             fault_q;

    // LOCK comes from the PLL's own domain; two flops before anything looks at it.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking here is what makes this a two-stage chain; blocking
            // assignments would collapse both stages into a single flop.
            sync1_q <= locked_async;
            lk_q    <= sync1_q;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default before the case, so a path that
        // does not assign one holds its register instead of inferring a latch.
        state_d = state_q;
        ctr_d   = ctr_q;
        att_d   = att_q;
        loss_d  = loss_q;

        case (state_q)
            ST_PLL_RST: begin
                if (ctr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = ST_STABLE;
                    ctr_d   = '0;
                end else if (ctr_q == TMO_LAST) begin
                    att_d   = att_q + 3'd1;
                    ctr_d   = '0;
                    state_d = (att_d == ATT_MAX) ? ST_FAULT : ST_PLL_RST;
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end

            // A dropout while qualifying restarts the wait without costing an attempt.
            ST_STABLE: begin
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                    ctr_d   = '0;
                end else if (ctr_q == STB_LAST) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                    att_d   = 3'd0;
                end else begin
                    ctr_d = ctr_q + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (!lk_q) begin
                    state_d = ST_PLL_RST;
                    ctr_d   = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end

            ST_FAULT: begin
                if (retry) begin
                    state_d = ST_PLL_RST;
                    ctr_d   = '0;
                    att_d   = 3'd0;
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                ctr_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_PLL_RST;
            ctr_q    <= '0;
            att_q    <= 3'd0;
            loss_q   <= 8'd0;
            resetb_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            att_q    <= att_d;
            loss_q   <= loss_d;
            resetb_q <= (state_d != ST_PLL_RST) && (state_d != ST_FAULT);
            ready_q  <= (state_d == ST_RUN);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    assign pll_resetb    = resetb_q;
    assign sys_ready     = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign attempt_count = att_q;
    assign loss_count    = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with shortened timing: expected state-change events are
// queued by the stimulus and checked, with their cycle stamps, by an independent monitor.
module tb_pll_lock_sequencer;

    localparam int R = 16;
    localparam int T = 100;
    localparam int S = 32;
    localparam int M = 7;
    localparam int P = R + T;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STB  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    typedef struct {
        int          cyc;
        logic [16:0] outs;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       locked_async;
    logic       retry;
    logic       pll_resetb;
    logic       sys_ready;
    logic       fault;
    logic [2:0] state;
    logic [2:0] attempt_count;
    logic [7:0] loss_count;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    ev_t        exp_q[$];
    logic [7:0] exp_loss;

    pll_lock_sequencer #(
        .RESET_CYCLES (R),
        .LOCK_TIMEOUT (T),
        .STABLE_CYCLES(S),
        .MAX_ATTEMPTS (M),
        .CNT_W        (16)
    ) dut (
        .clock_in     (clk),
        .reset_n      (reset_n),
        .locked_async (locked_async),
        .retry        (retry),
        .pll_resetb   (pll_resetb),
        .sys_ready    (sys_ready),
        .fault        (fault),
        .state        (state),
        .attempt_count(attempt_count),
        .loss_count   (loss_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) neg();
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic [2:0] att,
                        input logic [7:0] loss);
        ev_t e;
        e.cyc  = c;
        e.outs = {(st != S_RST) && (st != S_FLT), st == S_RUN, st == S_FLT, st, att, loss};
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pll_resetb"}, 32'(pll_resetb), 32'd0);
        check({tag, "_sys_ready"},  32'(sys_ready),  32'd0);
        check({tag, "_fault"},      32'(fault),      32'd0);
        check({tag, "_state"},      32'(state),      32'(S_RST));
        check({tag, "_attempts"},   32'(attempt_count), 32'd0);
        check({tag, "_loss"},       32'(loss_count), 32'd0);
    endtask

    // From RUN: drop LOCK, re-raise it 5 cycles later, optionally glitch it mid-STABLE.
    task automatic drop_and_relock(input bit glitch);
        int d;
        int s;
        int g;
        int run;
        d = cyc;
        locked_async = 1'b0;
        if (exp_loss != 8'hFF) exp_loss++;
        push(d + 3,     S_RST,  3'd0, exp_loss);
        push(d + 3 + R, S_WAIT, 3'd0, exp_loss);
        s = d + 4 + R;
        push(s,         S_STB,  3'd0, exp_loss);
        wait_until(d + 5);
        locked_async = 1'b1;
        if (glitch) begin
            g = s + S / 2;
            wait_until(g);
            locked_async = 1'b0;
            neg();
            locked_async = 1'b1;
            push(g + 3, S_WAIT, 3'd0, exp_loss);
            push(g + 4, S_STB,  3'd0, exp_loss);
            run = g + 4 + S;
        end else begin
            run = s + S;
        end
        push(run, S_RUN, 3'd0, exp_loss);
        wait_until(run + 3);
    endtask

    // Monitor: every state change the DUT presents out of reset must match the queue head.
    initial begin
        logic [2:0] prev;
        ev_t        e;
        prev = S_RST;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = state;
            end else if (state !== prev) begin
                prev = state;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_event: state %0d at cycle %0d, none expected",
                             state, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_outputs",
                          {15'd0, pll_resetb, sys_ready, fault, state, attempt_count, loss_count},
                          {15'd0, e.outs});
                end
            end
        end
    end

    initial begin
        int r;
        int c;
        int d;
        int w;
        int t;
        int f;

        reset_n      = 1'b0;
        locked_async = 1'b0;
        retry        = 1'b0;
        exp_loss     = 8'd0;
        repeat (3) neg();
        check_reset_outputs("por");

        // Clean power-up: RESETB low exactly R cycles, ready 2+S+1 cycles after LOCK.
        reset_n = 1'b1;
        r = cyc;
        push(r + R, S_WAIT, 3'd0, 8'd0);
        wait_until(r + R + 40);
        c = cyc;
        locked_async = 1'b1;
        push(c + 3,     S_STB, 3'd0, 8'd0);
        push(c + 3 + S, S_RUN, 3'd0, 8'd0);
        wait_until(c + 3 + S + 3);

        // Three RUN losses, the second with a one-cycle LOCK glitch during qualification.
        drop_and_relock(1'b0);
        drop_and_relock(1'b1);
        drop_and_relock(1'b0);
        check("loss_after_3", 32'(loss_count), 32'd3);

        retry = 1'b1;
        neg();
        retry = 1'b0;
        repeat (4) neg();
        check("retry_in_run_state", 32'(state), 32'(S_RUN));
        check("retry_in_run_ready", 32'(sys_ready), 32'd1);

        // Asynchronous reset mid-RUN, then mid-STABLE.
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        neg();
        neg();
        reset_n  = 1'b1;
        exp_loss = 8'd0;
        r = cyc;
        push(r + R,     S_WAIT, 3'd0, 8'd0);
        push(r + R + 1, S_STB,  3'd0, 8'd0);
        wait_until(r + R + 1 + 10);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_stable");
        neg();
        neg();
        reset_n = 1'b1;
        r = cyc;
        push(r + R,         S_WAIT, 3'd0, 8'd0);
        push(r + R + 1,     S_STB,  3'd0, 8'd0);
        push(r + R + 1 + S, S_RUN,  3'd0, 8'd0);
        wait_until(r + R + 1 + S + 3);

        // LOCK lost for good: M timed-out attempts, then FAULT.
        d = cyc;
        locked_async = 1'b0;
        exp_loss = 8'd1;
        push(d + 3, S_RST, 3'd0, 8'd1);
        w = d + 3 + R;
        push(w, S_WAIT, 3'd0, 8'd1);
        for (int k = 0; k < M; k++) begin
            t = w + k * P + T;
            if (k == M - 1) begin
                push(t, S_FLT, 3'(M), 8'd1);
            end else begin
                push(t,     S_RST,  3'(k + 1), 8'd1);
                push(t + R, S_WAIT, 3'(k + 1), 8'd1);
            end
        end
        wait_until(w + (M - 1) * P + T + 5);
        check("fault_flag",     32'(fault),         32'd1);
        check("fault_state",    32'(state),         32'(S_FLT));
        check("fault_resetb",   32'(pll_resetb),    32'd0);
        check("fault_attempts", 32'(attempt_count), 32'(M));

        // Retry out of FAULT with LOCK now available.
        f = cyc;
        retry = 1'b1;
        locked_async = 1'b1;
        push(f + 1,         S_RST,  3'd0, 8'd1);
        push(f + 1 + R,     S_WAIT, 3'd0, 8'd1);
        push(f + 2 + R,     S_STB,  3'd0, 8'd1);
        push(f + 2 + R + S, S_RUN,  3'd0, 8'd1);
        neg();
        retry = 1'b0;
        wait_until(f + 2 + R + S + 3);

        // Drive loss_count into saturation.
        for (int i = 0; i < 256; i++) drop_and_relock(1'b0);
        check("loss_saturated", 32'(loss_count), 32'd255);

        retry = 1'b1;
        neg();
        retry = 1'b0;
        repeat (4) neg();
        check("retry_sat_state", 32'(state),      32'(S_RUN));
        check("retry_sat_loss",  32'(loss_count), 32'd255);

        repeat (5) neg();
        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
